gtx_rst_seq: RTL and testbench
==============================

// Module: gtx_rst_seq
// PURPOSE
//  GTX reset/handshake sequencer directly upstream of the OOB controller. Brings the transceiver out of
//  reset after CPLL lock and produces gtx_ready. Then services the OOB controller's partial-reset and
//  clock-align requests: txpcsreset_req->recal_tx_done, rxreset_req->rxreset_ack, clk_phase_align_req->ack.
//  Sits between the GTX wrapper and oob_ctrl in the SATA host PHY.
// PARAMETERS
//  RST_PULSE   8   cycles each GTX reset output is held high (min 1)
//  TIMEOUT_W   16  width of watchdog counter; timeout = 2**TIMEOUT_W-1 cycles in any wait state
//  SYNC_STAGES 2   flop stages on GTX status inputs (cplllock, *resetdone, rxdlysresetdone)
// PORTS
//  clk                 in  1  sata clk = usrclk2
//  rst                 in  1  asynchronous, active-high reset
//  cplllock            in  1  GTX CPLL locked (async)
//  txresetdone         in  1  GTX TX reset done (async)
//  rxresetdone         in  1  GTX RX reset done (async)
//  rxdlysresetdone     in  1  GTX RX delay-align reset done (async)
//  txpcsreset_req      in  1  1-cycle pulse from oob_ctrl: partial TX PCS reset
//  rxreset_req         in  1  1-cycle pulse from oob_ctrl: RX reset
//  clk_phase_align_req in  1  1-cycle pulse from oob_ctrl: RX clock phase align
//  gttxreset           out 1  full GTX TX reset
//  gtrxreset           out 1  full GTX RX reset
//  txpcsreset          out 1  GTX TX PCS reset
//  rxpcsreset          out 1  GTX RX PCS reset
//  rxdlysreset         out 1  GTX RX delay-align reset
//  gtx_ready           out 1  transceiver usable; to oob_ctrl
//  recal_tx_done       out 1  1-cycle pulse: TX PCS reset complete
//  rxreset_ack         out 1  1-cycle pulse: RX reset complete
//  clk_phase_align_ack out 1  1-cycle pulse: phase align complete
//  timeout_err         out 1  sticky; set on any watchdog expiry, cleared only by rst
// BEHAVIOUR
//  Reset (rst=1, async): state=WAIT_LOCK; gttxreset=gtrxreset=1; all other outputs 0; pending flags,
//  counters and synchronizers cleared. Status inputs are used only after SYNC_STAGES synchronization.
//  States/transitions (cnt = shared pulse/watchdog counter, cleared on every state entry):
//   WAIT_LOCK : gt*reset=1; cplllock_s -> GT_RST
//   GT_RST    : gt*reset=1 for RST_PULSE cycles -> GT_WAIT
//   GT_WAIT   : gt*reset=0; txresetdone_s&rxresetdone_s -> READY (gtx_ready=1 on the next cycle)
//   READY     : gtx_ready=1; service pending requests, priority tx > rx > align
//   TX_RST    : txpcsreset=1 for RST_PULSE cycles -> TX_WAIT
//   TX_WAIT   : txresetdone_s=1 -> READY, recal_tx_done pulses in the transition cycle
//   RX_RST    : rxpcsreset=1 for RST_PULSE cycles -> RX_WAIT
//   RX_WAIT   : rxresetdone_s=1 -> READY, rxreset_ack pulses in the transition cycle
//   AL_RST    : rxdlysreset=1 until rxdlysresetdone_s=1 -> READY, clk_phase_align_ack pulses
//  gtx_ready stays 1 in TX_*/RX_*/AL_RST; oob_ctrl must not see it drop during partial resets.
//  Requests are latched into pending flags in any state. A request whose type is already pending or in
//  service merges into it (one ack). Each flag clears on entry to its service state.
//  Latency, READY with one pending request: reset output rises on the next cycle.
//  *_WAIT ignore resetdone during the first SYNC_STAGES+1 cycles, so a stale high level is not taken as done.
//  Watchdog: in GT_WAIT/TX_WAIT/RX_WAIT/AL_RST, cnt reaching all-ones -> set timeout_err, drop gtx_ready,
//   discard pending requests, go GT_RST (full re-init; no ack issued).
//  cplllock_s falling in any state except WAIT_LOCK -> gtx_ready=0 same cycle as detection, pending cleared,
//   -> WAIT_LOCK. This has priority over all other transitions.
//  cnt width = max(TIMEOUT_W, clog2(RST_PULSE+1)); it saturates and never wraps.
// STRUCTURE
//  Shared SATA PHY package/header: state encoding localparams (WAIT_LOCK..AL_RST).
//  One sub-module: gtx_status_sync (SYNC_STAGES-deep 2-FF-style synchronizer, vector width 4, async rst).
//  The FSM, counter and pending flags stay in gtx_rst_seq.
// TESTING
//  1 rst, cplllock=1 at t=10, resetdone rise 50 cycles after gt*reset fall -> gt*reset high 8 cycles,
//    then gtx_ready=1 and stays 1.
//  2 READY, txpcsreset_req pulse, txresetdone low 20 cycles then high -> txpcsreset 8 cycles, one
//    recal_tx_done pulse, gtx_ready never drops.
//  3 txpcsreset_req and rxreset_req in the same cycle -> TX served first, then RX; exactly one ack each, in order.
//  4 rxreset_req twice while RX_WAIT is active -> single rxreset_ack; no second RX reset.
//  5 TIMEOUT_W=6, rxresetdone stuck low after rxreset_req -> timeout_err=1 after 63 cycles, no ack,
//    gtx_ready=0, GT_RST re-entered.
//  6 cplllock drops mid AL_RST -> gtx_ready=0 within SYNC_STAGES+1 cycles, WAIT_LOCK, no
//    clk_phase_align_ack; async rst mid TX_RST -> all outputs at reset values immediately.

Source files
------------

// File: rtl/gtx_rst_seq_pkg.sv
// Shared definitions for the SATA host PHY GTX reset sequencer: FSM state encoding,
// status-synchronizer bit positions and the counter-width helper.
package gtx_rst_seq_pkg;

    typedef enum logic [3:0] {
        StWaitLock = 4'd0,
        StGtRst    = 4'd1,
        StGtWait   = 4'd2,
        StReady    = 4'd3,
        StTxRst    = 4'd4,
        StTxWait   = 4'd5,
        StRxRst    = 4'd6,
        StRxWait   = 4'd7,
        StAlRst    = 4'd8
    } gtx_state_e;

    // Bit positions of the GTX status inputs inside the synchronized vector.
    localparam int unsigned StsW       = 4;
    localparam int unsigned StsLock    = 0;
    localparam int unsigned StsTxDone  = 1;
    localparam int unsigned StsRxDone  = 2;
    localparam int unsigned StsDlyDone = 3;

    // The shared counter must hold both the reset pulse length and the watchdog limit.
    function automatic int unsigned cnt_width(input int unsigned timeout_w,
                                              input int unsigned rst_pulse);
        int unsigned pulse_w;
        pulse_w = $clog2(rst_pulse + 1);
        return (timeout_w > pulse_w) ? timeout_w : pulse_w;
    endfunction

endpackage

// File: rtl/gtx_status_sync.sv
// Multi-stage flop synchronizer for the asynchronous GTX status levels.
module gtx_status_sync #(
    parameter int unsigned Width  = 4,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/gtx_rst_seq.sv
// GTX reset/handshake sequencer: initial bring-up after CPLL lock, then partial TX/RX resets
// and RX phase-align requests from the OOB controller, with a watchdog on every wait state.
module gtx_rst_seq
    import gtx_rst_seq_pkg::*;
#(
    parameter int unsigned RstPulse   = 8,
    parameter int unsigned TimeoutW   = 16,
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cplllock_i,
    input  logic txresetdone_i,
    input  logic rxresetdone_i,
    input  logic rxdlysresetdone_i,
    input  logic txpcsreset_req_i,
    input  logic rxreset_req_i,
    input  logic clk_phase_align_req_i,
    output logic gttxreset_o,
    output logic gtrxreset_o,
    output logic txpcsreset_o,
    output logic rxpcsreset_o,
    output logic rxdlysreset_o,
    output logic gtx_ready_o,
    output logic recal_tx_done_o,
    output logic rxreset_ack_o,
    output logic clk_phase_align_ack_o,
    output logic timeout_err_o
);

    localparam int unsigned      CntW      = cnt_width(TimeoutW, RstPulse);
    localparam logic [CntW-1:0] CntMax    = '1;
    localparam logic [CntW-1:0] PulseLast = CntW'(RstPulse - 1);
    // resetdone is only trusted once a full synchronizer flush has happened in the wait state.
    localparam logic [CntW-1:0] BlankLast = CntW'(SyncStages);

    gtx_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_pend_q, tx_pend_d;
    logic            rx_pend_q, rx_pend_d;
    logic            al_pend_q, al_pend_d;
    logic            timeout_err_q, timeout_err_d;

    logic [StsW-1:0] sts_raw, sts_s;
    logic            lock_s, tx_done_s, rx_done_s, dly_done_s;
    logic            lock_lost, wd_expired, blank_over, timeout_hit;

    assign sts_raw = {rxdlysresetdone_i, rxresetdone_i, txresetdone_i, cplllock_i};

    gtx_status_sync #(
        .Width  (StsW),
        .Stages (SyncStages)
    ) u_status_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sts_raw),
        .q_o   (sts_s)
    );

    assign lock_s     = sts_s[StsLock];
    assign tx_done_s  = sts_s[StsTxDone];
    assign rx_done_s  = sts_s[StsRxDone];
    assign dly_done_s = sts_s[StsDlyDone];

    assign lock_lost  = (state_q != StWaitLock) && !lock_s;
    assign wd_expired = (cnt_q == CntMax);
    assign blank_over = (cnt_q > BlankLast);

    always_comb begin
        state_d               = state_q;
        timeout_hit           = 1'b0;
        gttxreset_o           = 1'b0;
        gtrxreset_o           = 1'b0;
        txpcsreset_o          = 1'b0;
        rxpcsreset_o          = 1'b0;
        rxdlysreset_o         = 1'b0;
        gtx_ready_o           = 1'b0;
        recal_tx_done_o       = 1'b0;
        rxreset_ack_o         = 1'b0;
        clk_phase_align_ack_o = 1'b0;

        case (state_q)
            StWaitLock: begin
                gttxreset_o = 1'b1;
                gtrxreset_o = 1'b1;
                if (lock_s) begin
                    state_d = StGtRst;
                end
            end
            StGtRst: begin
                gttxreset_o = 1'b1;
                gtrxreset_o = 1'b1;
                if (cnt_q == PulseLast) begin
                    state_d = StGtWait;
                end
            end
            StGtWait: begin
                if (blank_over && tx_done_s && rx_done_s) begin
                    state_d = StReady;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            StReady: begin
                gtx_ready_o = 1'b1;
                if (tx_pend_q) begin
                    state_d = StTxRst;
                end else if (rx_pend_q) begin
                    state_d = StRxRst;
                end else if (al_pend_q) begin
                    state_d = StAlRst;
                end
            end
            StTxRst: begin
                gtx_ready_o  = 1'b1;
                txpcsreset_o = 1'b1;
                if (cnt_q == PulseLast) begin
                    state_d = StTxWait;
                end
            end
            StTxWait: begin
                gtx_ready_o = 1'b1;
                if (blank_over && tx_done_s) begin
                    recal_tx_done_o = 1'b1;
                    state_d         = StReady;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            StRxRst: begin
                gtx_ready_o  = 1'b1;
                rxpcsreset_o = 1'b1;
                if (cnt_q == PulseLast) begin
                    state_d = StRxWait;
                end
            end
            StRxWait: begin
                gtx_ready_o = 1'b1;
                if (blank_over && rx_done_s) begin
                    rxreset_ack_o = 1'b1;
                    state_d       = StReady;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            StAlRst: begin
                gtx_ready_o   = 1'b1;
                rxdlysreset_o = 1'b1;
                if (dly_done_s) begin
                    clk_phase_align_ack_o = 1'b1;
                    state_d               = StReady;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase

        if (timeout_hit) begin
            gtx_ready_o = 1'b0;
            state_d     = StGtRst;
        end

        // Losing the PLL overrides everything, including a watchdog hit in the same cycle.
        if (lock_lost) begin
            timeout_hit           = 1'b0;
            gtx_ready_o           = 1'b0;
            recal_tx_done_o       = 1'b0;
            rxreset_ack_o         = 1'b0;
            clk_phase_align_ack_o = 1'b0;
            state_d               = StWaitLock;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A request for a type already in service merges into the running operation.
    always_comb begin
        tx_pend_d = tx_pend_q | (txpcsreset_req_i &&
                                 !(state_q inside {StTxRst, StTxWait}));
        rx_pend_d = rx_pend_q | (rxreset_req_i &&
                                 !(state_q inside {StRxRst, StRxWait}));
        al_pend_d = al_pend_q | (clk_phase_align_req_i && (state_q != StAlRst));

        if (state_d == StTxRst && state_q != StTxRst) begin
            tx_pend_d = 1'b0;
        end
        if (state_d == StRxRst && state_q != StRxRst) begin
            rx_pend_d = 1'b0;
        end
        if (state_d == StAlRst && state_q != StAlRst) begin
            al_pend_d = 1'b0;
        end
        if (lock_lost || timeout_hit) begin
            tx_pend_d = 1'b0;
            rx_pend_d = 1'b0;
            al_pend_d = 1'b0;
        end
    end

    assign timeout_err_d = timeout_err_q | timeout_hit;
    assign timeout_err_o = timeout_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StWaitLock;
            cnt_q         <= '0;
            tx_pend_q     <= 1'b0;
            rx_pend_q     <= 1'b0;
            al_pend_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_pend_q     <= tx_pend_d;
            rx_pend_q     <= rx_pend_d;
            al_pend_q     <= al_pend_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_gtx_rst_seq.sv
// Scoreboard bench for gtx_rst_seq: directed GTX status/request sequences push expected
// handshake events; a negedge monitor pops and compares each event the DUT produces.
module tb_gtx_rst_seq;

    localparam int unsigned RstPulse   = 8;
    localparam int unsigned TimeoutW   = 6;
    localparam int unsigned SyncStages = 2;

    typedef enum int {EvReady, EvNotReady, EvTxDone, EvRxAck, EvAlAck, EvTimeout} ev_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cplllock = 1'b0, txresetdone = 1'b0, rxresetdone = 1'b0, rxdlysresetdone = 1'b0;
    logic txpcsreset_req = 1'b0, rxreset_req = 1'b0, clk_phase_align_req = 1'b0;
    logic gttxreset, gtrxreset, txpcsreset, rxpcsreset, rxdlysreset;
    logic gtx_ready, recal_tx_done, rxreset_ack, clk_phase_align_ack, timeout_err;

    int checks = 0;
    int errors = 0;
    ev_e exp_q[$];

    int tx_rises = 0, tx_len = 0, rx_rises = 0, rx_len = 0;
    logic rdy_prev = 1'b0, to_prev = 1'b0, txp_prev = 1'b0, rxp_prev = 1'b0;

    always #5 clk = ~clk;

    gtx_rst_seq #(
        .RstPulse   (RstPulse),
        .TimeoutW   (TimeoutW),
        .SyncStages (SyncStages)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .cplllock_i            (cplllock),
        .txresetdone_i         (txresetdone),
        .rxresetdone_i         (rxresetdone),
        .rxdlysresetdone_i     (rxdlysresetdone),
        .txpcsreset_req_i      (txpcsreset_req),
        .rxreset_req_i         (rxreset_req),
        .clk_phase_align_req_i (clk_phase_align_req),
        .gttxreset_o           (gttxreset),
        .gtrxreset_o           (gtrxreset),
        .txpcsreset_o          (txpcsreset),
        .rxpcsreset_o          (rxpcsreset),
        .rxdlysreset_o         (rxdlysreset),
        .gtx_ready_o           (gtx_ready),
        .recal_tx_done_o       (recal_tx_done),
        .rxreset_ack_o         (rxreset_ack),
        .clk_phase_align_ack_o (clk_phase_align_ack),
        .timeout_err_o         (timeout_err)
    );

    task automatic observe(input ev_e ev);
        ev_e want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_event: got %s, expected no event", ev.name());
        end else begin
            want = exp_q.pop_front();
            if (want != ev) begin
                errors++;
                $display("FAIL sb_event: got %s, expected %s", ev.name(), want.name());
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic wait_sb(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events not seen, next %s, after %0d cycles",
                     name, exp_q.size(), exp_q[0].name(), n);
            exp_q.delete();
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (recal_tx_done) observe(EvTxDone);
        if (rxreset_ack) observe(EvRxAck);
        if (clk_phase_align_ack) observe(EvAlAck);
        if (gtx_ready && !rdy_prev) observe(EvReady);
        if (!gtx_ready && rdy_prev) observe(EvNotReady);
        if (timeout_err && !to_prev) observe(EvTimeout);
        if (txpcsreset) begin
            if (!txp_prev) begin
                tx_rises++;
                tx_len = 0;
            end
            tx_len++;
        end
        if (rxpcsreset) begin
            if (!rxp_prev) begin
                rx_rises++;
                rx_len = 0;
            end
            rx_len++;
        end
        rdy_prev = gtx_ready;
        to_prev  = timeout_err;
        txp_prev = txpcsreset;
        rxp_prev = rxpcsreset;
    end

    function automatic logic [9:0] out_vec();
        return {gttxreset, gtrxreset, txpcsreset, rxpcsreset, rxdlysreset,
                gtx_ready, recal_tx_done, rxreset_ack, clk_phase_align_ack, timeout_err};
    endfunction

    initial begin
        int n;
        int tx0, rx0;

        // 1: reset values, bring-up after lock
        #1 rst = 1'b1;
        #1 check("reset_outputs_async", 32'(out_vec()), 32'(10'b1100000000));
        tick(3);
        check("reset_outputs_held", 32'(out_vec()), 32'(10'b1100000000));
        rst = 1'b0;
        tick(10);
        check("wait_lock_gttxreset", 32'(gttxreset), 1);
        check("wait_lock_not_ready", 32'(gtx_ready), 0);
        cplllock = 1'b1;
        n = 0;
        while (gttxreset && n < 40) begin
            tick(1);
            n++;
        end
        check("gt_reset_release_cycles", n, SyncStages + 1 + RstPulse);
        check("gtrxreset_released", 32'(gtrxreset), 0);
        exp_q.push_back(EvReady);
        tick(49);
        txresetdone = 1'b1;
        rxresetdone = 1'b1;
        wait_sb("bringup_ready", 20);
        tick(5);
        check("ready_held", 32'(gtx_ready), 1);

        // 2: partial TX PCS reset
        tx0 = tx_rises;
        txpcsreset_req = 1'b1;
        txresetdone = 1'b0;
        exp_q.push_back(EvTxDone);
        tick(1);
        txpcsreset_req = 1'b0;
        tick(19);
        txresetdone = 1'b1;
        wait_sb("tx_recal", 60);
        check("txpcsreset_pulse_len", tx_len, RstPulse);
        check("txpcsreset_pulse_count", tx_rises - tx0, 1);

        // 3: simultaneous TX and RX requests, TX first
        tick(3);
        tx0 = tx_rises;
        rx0 = rx_rises;
        txpcsreset_req = 1'b1;
        rxreset_req = 1'b1;
        txresetdone = 1'b0;
        rxresetdone = 1'b0;
        exp_q.push_back(EvTxDone);
        exp_q.push_back(EvRxAck);
        tick(1);
        txpcsreset_req = 1'b0;
        rxreset_req = 1'b0;
        tick(19);
        txresetdone = 1'b1;
        tick(30);
        rxresetdone = 1'b1;
        wait_sb("tx_then_rx", 80);
        check("dual_tx_count", tx_rises - tx0, 1);
        check("dual_rx_count", rx_rises - rx0, 1);
        check("rxpcsreset_pulse_len", rx_len, RstPulse);

        // 4: repeated RX requests while RX_WAIT is active merge
        tick(3);
        rx0 = rx_rises;
        rxreset_req = 1'b1;
        rxresetdone = 1'b0;
        exp_q.push_back(EvRxAck);
        tick(1);
        rxreset_req = 1'b0;
        tick(11);
        check("in_rx_wait", 32'(rxpcsreset), 0);
        rxreset_req = 1'b1;
        tick(1);
        rxreset_req = 1'b0;
        tick(2);
        rxreset_req = 1'b1;
        tick(1);
        rxreset_req = 1'b0;
        tick(3);
        rxresetdone = 1'b1;
        wait_sb("rx_merge_ack", 40);
        tick(20);
        check("rx_merge_single_reset", rx_rises - rx0, 1);

        // 5: RX reset with resetdone stuck low -> watchdog
        tick(2);
        rxreset_req = 1'b1;
        rxresetdone = 1'b0;
        exp_q.push_back(EvNotReady);
        exp_q.push_back(EvTimeout);
        tick(1);
        rxreset_req = 1'b0;
        n = 0;
        while (!rxpcsreset && n < 20) begin
            tick(1);
            n++;
        end
        while (rxpcsreset && n < 40) begin
            tick(1);
            n++;
        end
        check("rx_wait_entered", 32'(n < 40), 1);
        n = 0;
        while (gtx_ready && n < 100) begin
            tick(1);
            n++;
        end
        check("watchdog_cycles", n, (1 << TimeoutW) - 1);
        tick(1);
        check("timeout_err_set", 32'(timeout_err), 1);
        check("gt_rst_reentered", 32'(gttxreset), 1);
        rxresetdone = 1'b1;
        exp_q.push_back(EvReady);
        wait_sb("timeout_recovery", 40);
        check("timeout_err_sticky", 32'(timeout_err), 1);

        // 6: lock loss in the middle of AL_RST
        tick(3);
        clk_phase_align_req = 1'b1;
        tick(1);
        clk_phase_align_req = 1'b0;
        n = 0;
        while (!rxdlysreset && n < 10) begin
            tick(1);
            n++;
        end
        check("al_rst_entered", 32'(rxdlysreset), 1);
        tick(3);
        cplllock = 1'b0;
        exp_q.push_back(EvNotReady);
        n = 0;
        while (gtx_ready && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (gtx_ready || n > SyncStages + 1) begin
            errors++;
            $display("FAIL lockloss_latency: got %0d cycles, required <= %0d",
                     n, SyncStages + 1);
        end
        tick(1);
        check("lockloss_wait_lock", 32'({gttxreset, rxdlysreset}), 32'(2'b10));
        rxdlysresetdone = 1'b1;
        tick(5);
        rxdlysresetdone = 1'b0;
        cplllock = 1'b1;
        exp_q.push_back(EvReady);
        wait_sb("relock_ready", 60);

        // Async reset mid TX_RST
        tick(2);
        txpcsreset_req = 1'b1;
        txresetdone = 1'b0;
        tick(1);
        txpcsreset_req = 1'b0;
        n = 0;
        while (!txpcsreset && n < 10) begin
            tick(1);
            n++;
        end
        check("tx_rst_entered", 32'(txpcsreset), 1);
        tick(2);
        #2;
        exp_q.push_back(EvNotReady);
        rst = 1'b1;
        #1 check("async_rst_outputs", 32'(out_vec()), 32'(10'b1100000000));
        cplllock = 1'b0;
        tick(3);
        rst = 1'b0;
        wait_sb("async_rst_events", 5);
        tick(5);
        check("post_rst_wait_lock", 32'(out_vec()), 32'(10'b1100000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
